// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/data/handshake bundle between four source lanes, the arbiter and the consumer
interface mux4_rr_arbiter_if #(
  parameter int DW = 1
);
  logic [3:0]      req;
  logic [4*DW-1:0] i;
  logic            out_ready;
  logic [3:0]      gnt;
  logic [1:0]      s;
  logic [DW-1:0]   y;
  logic            valid;

  // master is the arbiter side; slave is the sources plus downstream consumer
  modport master (
    input  req, i, out_ready,
    output gnt, s, y, valid
  );

  modport slave (
    output req, i, out_ready,
    input  gnt, s, y, valid
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter steering one of four lanes onto a single valid/ready output
module mux4_rr_arbiter #(
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.master bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    s_q, s_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    win;
  logic [1:0]    cand;
  logic          win_found;
  logic          req_cur;
  logic          valid_w;
  logic          accept;
  logic          last_beat;
  logic [DW-1:0] lane_data;

  // Scan priority order ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps mod 4.
  always_comb begin
    win       = ptr_q;
    cand      = ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  assign req_cur   = bus.req[s_q];
  assign valid_w   = (state_q == GRANT) && req_cur;
  assign accept    = valid_w && bus.out_ready;
  assign last_beat = (cnt_q == CW'(MAX_BURST - 1));
  assign lane_data = bus.i[int'(s_q)*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          s_d     = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A dropped request or the final beat both rotate priority past the current lane.
        if (!req_cur || (accept && last_beat)) begin
          state_d = IDLE;
          ptr_d   = s_q + 2'd1;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt   = (state_q == GRANT) ? (4'b0001 << s_q) : 4'b0000;
  assign bus.s     = s_q;
  assign bus.valid = valid_w;
  assign bus.y     = valid_w ? lane_data : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter with a behavioural reference model
module tb_mux4_rr_arbiter;

  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst;

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // reference model: granted flag, owning lane, rotation pointer, beats taken so far
  bit m_granted;
  int m_lane;
  int m_ptr;
  int m_beats;

  int grant_seq[$];
  int beats_seq[$];
  bit last_gnt_nz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_release();
    m_granted = 1'b0;
    m_ptr     = (m_lane + 1) % 4;
    m_beats   = 0;
  endtask

  // one clock: drive inputs, check outputs against the model, advance model across the edge
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [4*DW-1:0] data, input logic rdy);
    logic          e_valid;
    logic [3:0]    e_gnt;
    logic [DW-1:0] e_y;
    int            w;
    rst           = r;
    bus.req       = rq;
    bus.i         = data;
    bus.out_ready = rdy;
    #1;
    e_valid = m_granted && rq[m_lane];
    e_gnt   = m_granted ? (4'b0001 << m_lane) : 4'b0000;
    e_y     = e_valid ? data[m_lane*DW +: DW] : '0;
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("s", 32'(bus.s), 32'(m_lane));
    chk("valid", 32'(bus.valid), 32'(e_valid));
    chk("y", 32'(bus.y), 32'(e_y));
    if (bus.gnt != 4'b0000 && !last_gnt_nz) begin
      grant_seq.push_back(int'(bus.s));
      beats_seq.push_back(0);
    end
    if (bus.valid && rdy && beats_seq.size() > 0)
      beats_seq[beats_seq.size()-1] = beats_seq[beats_seq.size()-1] + 1;
    last_gnt_nz = (bus.gnt != 4'b0000);
    @(posedge clk);
    if (r) begin
      m_granted = 1'b0;
      m_lane    = 0;
      m_ptr     = 0;
      m_beats   = 0;
    end else if (!m_granted) begin
      w = pick_winner(rq, m_ptr);
      if (w >= 0) begin
        m_granted = 1'b1;
        m_lane    = w;
        m_beats   = 0;
      end
    end else if (!rq[m_lane]) begin
      model_release();
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MAX_BURST) model_release();
    end
    @(negedge clk);
  endtask

  function automatic logic [4*DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_seq();
    grant_seq.delete();
    beats_seq.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_granted = 1'b0;
    m_lane = 0;
    m_ptr = 0;
    m_beats = 0;
    last_gnt_nz = 1'b0;

    // first reset edge establishes known state before anything is compared
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.i = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // reset held with all lanes requesting
    for (int n = 0; n < 2; n++) cycle(1'b1, 4'b1111, rnd_data(), 1'b1);
    clear_seq();

    // full contention: 0,1,2,3,0 each 4 beats with 1-cycle bubbles
    for (int n = 0; n < 26; n++) cycle(1'b0, 4'b1111, rnd_data(), 1'b1);
    chk("contention_ngrants", 32'(grant_seq.size()), 32'd5);
    for (int n = 0; n < 5 && n < grant_seq.size(); n++) begin
      chk("contention_order", 32'(grant_seq[n]), 32'(n % 4));
      chk("contention_beats", 32'(beats_seq[n]), 32'd4);
    end

    // single requester on lane 2 is re-granted after one idle cycle
    cycle(1'b1, 4'b0000, '0, 1'b1);
    clear_seq();
    for (int n = 0; n < 11; n++) cycle(1'b0, 4'b0100, {8'h00, 8'h01, 8'h00, 8'h00}, 1'b1);
    chk("single_ngrants", 32'(grant_seq.size()), 32'd2);
    if (grant_seq.size() >= 2) begin
      chk("single_lane_a", 32'(grant_seq[0]), 32'd2);
      chk("single_lane_b", 32'(grant_seq[1]), 32'd2);
      chk("single_beats", 32'(beats_seq[0]), 32'd4);
    end

    // backpressure on lane 1: five stalled cycles then four accepted beats
    cycle(1'b1, 4'b0000, '0, 1'b1);
    clear_seq();
    cycle(1'b0, 4'b0010, rnd_data(), 1'b1);
    for (int n = 0; n < 5; n++) begin
      cycle(1'b0, 4'b0010, rnd_data(), 1'b0);
      chk("bp_s_stable", 32'(bus.s), 32'd1);
    end
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'b0010, rnd_data(), 1'b1);
    chk("bp_released", 32'(bus.gnt), 32'd0);
    chk("bp_beats", 32'(beats_seq.size() > 0 ? beats_seq[0] : -1), 32'd4);

    // early release on lane 3 wraps the pointer to lane 0
    cycle(1'b1, 4'b0000, '0, 1'b1);
    clear_seq();
    cycle(1'b0, 4'b1000, rnd_data(), 1'b1);
    for (int n = 0; n < 2; n++) cycle(1'b0, 4'b1001, rnd_data(), 1'b1);
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'b0001, rnd_data(), 1'b1);
    chk("early_ngrants", 32'(grant_seq.size()), 32'd2);
    if (grant_seq.size() >= 2) begin
      chk("early_first", 32'(grant_seq[0]), 32'd3);
      chk("early_beats", 32'(beats_seq[0]), 32'd2);
      chk("early_wrap", 32'(grant_seq[1]), 32'd0);
    end

    // reset mid-burst on lane 2 with cnt=2, then lane 1 wins from ptr 0
    cycle(1'b1, 4'b0000, '0, 1'b1);
    clear_seq();
    cycle(1'b0, 4'b0100, rnd_data(), 1'b1);
    for (int n = 0; n < 2; n++) cycle(1'b0, 4'b0100, rnd_data(), 1'b1);
    cycle(1'b1, 4'b0110, rnd_data(), 1'b1);
    chk("midrst_idle", 32'(bus.gnt), 32'd0);
    for (int n = 0; n < 2; n++) cycle(1'b0, 4'b0110, rnd_data(), 1'b1);
    chk("midrst_ngrants", 32'(grant_seq.size()), 32'd2);
    if (grant_seq.size() >= 2) chk("midrst_next", 32'(grant_seq[1]), 32'd1);

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [3:0] rq;
      rq = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 4'b0000;
      cycle(($urandom_range(0, 79) == 0), rq, rnd_data(), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 multiplexer datapath. It shares one output channel among four requesters. It chooses a winner and drives the mux select `s[1:0]`, then steers the winner's lane onto `y` under a valid/ready handshake. Each grant is held for a bounded burst so that no single requester can starve the others. The block sits between the four source lanes and a single downstream consumer.

## Interface
- `DW`, default 1: width of each data lane and of `y`.
- `MAX_BURST`, default 4: maximum accepted beats per grant before forced rotation; legal range ≥ 1.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `req`, input, 4: per-requester request; `req[k]` high means lane k has data.
- `i`, input, 4*DW: data lanes; lane k is `i[k*DW +: DW]`.
- `out_ready`, input, 1: downstream consumer can accept a beat this cycle.
- `gnt`, output, 4: one-hot grant, all-zero when idle.
- `s`, output, 2: registered mux select, the index of the granted lane.
- `y`, output, DW: selected lane data; forced to 0 when `valid` is low.
- `valid`, output, 1: `y` carries a beat.

## Operation
- State machine has two states.
  - IDLE: `gnt` = 0, `valid` = 0.
  - GRANT: `gnt` = one-hot(`s`).
- Round-robin pointer `ptr[1:0]` holds the highest-priority index. Priority order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- IDLE → GRANT happens when `req` ≠ 0.
  - Winner is the first set bit of `req` in priority order.
  - On that edge, `s` ← winner, `gnt` ← one-hot(winner), and burst counter `cnt` ← 0.
- In GRANT:
  - `valid` = `req[s]`.
  - `y` = lane `s` of `i`. This is a combinational path through the mux; `y` is 0 when `valid` = 0.
  - A beat is accepted when `valid && out_ready`; `cnt` then increments by 1.
- GRANT → IDLE happens on either of two conditions, whichever occurs first:
  - (a) `req[s]` is low. No beat transfers in this cycle.
  - (b) A beat is accepted and `cnt` = MAX_BURST−1, i.e. this is the final beat of the burst.
- On any GRANT → IDLE transition: `ptr` ← `s`+1 mod 4 (wraps 3 → 0), `gnt` ← 0, `cnt` ← 0. `s` holds its last value.
- Width of `cnt` is $clog2(MAX_BURST+1) bits; it never exceeds MAX_BURST−1 while in GRANT.
- Requests from non-granted lanes are ignored during GRANT; they do not preempt the current grant.
- `valid` may be high with `out_ready` low indefinitely. The grant, `s`, and `cnt` all hold, and `y` tracks lane `s` combinationally. Source lanes must hold data stable until the beat is accepted.

## Timing
- Reset values (taken at the first edge with `rst` = 1):
  - state = IDLE, `gnt` = 4'b0000, `s` = 2'b00, `ptr` = 2'b00, `cnt` = 0.
  - `valid` = 0, `y` = 0.
- Reset in mid-burst: `rst` overrides every other condition on that edge. No beat is considered accepted in that cycle, and `ptr` returns to 0.
- Request-to-grant latency is 1 cycle: `req` is sampled high in IDLE at edge n, and `gnt`/`valid` are high from edge n onward.
- After a transition into IDLE there is exactly 1 idle cycle before the next grant. Minimum spacing between grants is therefore 1 bubble cycle.
- Simultaneous events:
  - Final-beat accept and `req[s]` dropping on the same edge: not possible, because accepting a beat requires `req[s]` high. Condition (b) governs.
  - When all four requests are high continuously, grants rotate 0 → 1 → 2 → 3 → 0.
- `s` changes only on IDLE → GRANT edges. It is never glitch-driven by `req`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req` = 4'b1111.
  - Required: `gnt` = 0, `s` = 0, `valid` = 0, `y` = 0 throughout.
  - After release, the first grant goes to lane 0 one cycle later.
- **Single requester, DW=1, MAX_BURST=4:** `req` = 4'b0100, `i` = 4'b0100, `out_ready` = 1.
  - Required: `s` = 2'b10, `gnt` = 4'b0100, `y` = 1 for exactly 4 beats.
  - Then 1 idle cycle, then lane 2 is re-granted (`ptr` = 3, but only lane 2 is requesting).
- **Full contention:** `req` = 4'b1111 held, `out_ready` = 1.
  - Required: grant sequence 0, 1, 2, 3, 0.
  - Each grant lasts 4 valid cycles, separated by 1-cycle bubbles.
- **Backpressure:** lane 1 granted, `out_ready` low for 5 cycles.
  - Required: `valid` = 1, `cnt` held, `s` = 1 stable.
  - Once `out_ready` rises, 4 more beats are accepted before rotation.
- **Early release:** lane 3 granted; it drops `req[3]` after 2 accepted beats while `req[0]` is high.
  - Required: IDLE for one cycle, then lane 0 granted (pointer wrapped 3 → 0).
- **Reset mid-burst:** `rst` pulsed while lane 2 is in GRANT with `cnt` = 2.
  - Required: IDLE on the next edge with `ptr` = 0.
  - The following grant with `req` = 4'b0110 goes to lane 1.
